ff_stim_check: RTL and testbench

Self-checking stimulus generator and response checker for on-hardware validation of iCE40 flip-flop packing modes: clock enable, synchronous reset, synchronous set. It drives pseudo-random control and data vectors into a two-stage flip-flop DUT and compares the DUT outputs against an internal golden model. It reports a mismatch count, the first failing vector index, and a pass/fail verdict. It sits in pack-test top levels next to the flip-flop-mode DUT and connects to it with plain wires.

---
 rtl/ff_stim_check.sv | 179 +++++++++++++++++
 tb/tb_ff_stim_check.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ff_stim_check.sv
// Stimulus generator and golden-model checker for iCE40 FF packing tests.
// Drives CE / sync-reset / sync-set vectors and scores a two-stage DUT.
module ff_stim_check #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          NUM_VECTORS = 1024,
  parameter int          EXTRA_LAT   = 0,
  parameter int          ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             stim_cen,
  output logic             stim_rst,
  output logic             stim_ina,
  output logic             stim_inb,
  input  logic             resp_a,
  input  logic             resp_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_err_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int          TAGD  = 3 + EXTRA_LAT;
  localparam logic [15:0] LASTV = 16'(NUM_VECTORS - 1);
  localparam logic [2:0]  DLAST = 3'(3 + EXTRA_LAT);

  state_t           r_state;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_idx;
  logic [2:0]       r_dcnt;
  logic [3:0]       r_stim;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [15:0]      r_first;

  logic [TAGD-1:0]  r_tv;
  logic [15:0]      r_tidx [TAGD];
  logic             r_ma;
  logic             r_mb;
  logic             r_ea [EXTRA_LAT+1];
  logic             r_eb [EXTRA_LAT+1];

  logic [15:0]      w_lfsr_nx;
  logic [3:0]       w_vec;
  logic             w_clr;
  logic             w_mis;

  assign w_lfsr_nx = {1'b0, r_lfsr[15:1]}
                   ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  // Vector 0 forces both model FFs to a known value.
  assign w_vec = (r_idx == 16'd0) ? 4'b1110
               : {r_lfsr[0], r_lfsr[1] & r_lfsr[2],
                  r_lfsr[3], r_lfsr[4]};

  assign w_clr = (r_state == S_RUN) && (r_idx == 16'd0);

  assign w_mis = r_tv[TAGD-1]
               & ((resp_a != r_ea[EXTRA_LAT])
                | (resp_b != r_eb[EXTRA_LAT]));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_idx   <= 16'd0;
      r_dcnt  <= 3'd0;
      r_stim  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_stim <= 4'd0;
          if (start) begin
            r_state <= S_RUN;
            r_lfsr  <= SEED;
            r_idx   <= 16'd0;
          end
        end
        S_RUN: begin
          r_stim <= w_vec;
          r_lfsr <= w_lfsr_nx;
          r_idx  <= r_idx + 16'd1;
          r_busy <= 1'b1;
          r_done <= 1'b0;
          r_pass <= 1'b0;
          if (r_idx == LASTV) begin
            r_state <= S_DRAIN;
            r_dcnt  <= 3'd0;
          end
        end
        S_DRAIN: begin
          r_stim <= 4'd0;
          if (r_dcnt == DLAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err == '0);
          end else begin
            r_dcnt <= r_dcnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tv    <= '0;
      r_ma    <= 1'b0;
      r_mb    <= 1'b0;
      r_err   <= '0;
      r_first <= 16'hFFFF;
      for (int i = 0; i < TAGD; i++) begin
        r_tidx[i] <= 16'd0;
      end
      for (int i = 0; i <= EXTRA_LAT; i++) begin
        r_ea[i] <= 1'b0;
        r_eb[i] <= 1'b0;
      end
    end else begin
      r_tv[0]   <= (r_state == S_RUN);
      r_tidx[0] <= r_idx;
      for (int i = 1; i < TAGD; i++) begin
        r_tv[i]   <= r_tv[i-1];
        r_tidx[i] <= r_tidx[i-1];
      end
      // Stage 1: A has CE+sync reset, B has CE+sync set.
      if (r_stim[3]) begin
        r_ma <= r_stim[2] ? 1'b0 : r_stim[1];
      end
      if (r_stim[1]) begin
        r_mb <= r_stim[2] ? 1'b1 : r_stim[0];
      end
      r_ea[0] <= r_ma;
      r_eb[0] <= r_mb;
      for (int i = 1; i <= EXTRA_LAT; i++) begin
        r_ea[i] <= r_ea[i-1];
        r_eb[i] <= r_eb[i-1];
      end
      if (w_clr) begin
        r_err   <= '0;
        r_first <= 16'hFFFF;
      end else if (w_mis) begin
        if (r_err != {ERR_W{1'b1}}) begin
          r_err <= r_err + ERR_W'(1);
        end
        if (r_first == 16'hFFFF) begin
          r_first <= r_tidx[TAGD-1];
        end
      end
    end
  end

  assign stim_cen      = r_stim[3];
  assign stim_rst      = r_stim[2];
  assign stim_ina      = r_stim[1];
  assign stim_inb      = r_stim[0];
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err;
  assign first_err_idx = r_first;

endmodule

// File: tb/tb_ff_stim_check.sv
// Directed bench for ff_stim_check with behavioural two-stage FF DUTs.
// Covers clean/fault/hold/abort runs, saturation and extra latency.
module tb_ff_stim_check;

  localparam int N0 = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic inj = 1'b0;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  // u0: NUM_VECTORS=64, EXTRA_LAT=0
  logic s0_cen, s0_rst, s0_ina, s0_inb;
  logic r0_a, r0_b;
  logic u0_busy, u0_done, u0_pass;
  logic [7:0]  u0_err;
  logic [15:0] u0_first;
  logic a1_0, b1_0, a2_0, b2_0;
  logic [3:0] s0;

  assign s0   = {s0_cen, s0_rst, s0_ina, s0_inb};
  assign r0_a = a2_0 ^ inj;
  assign r0_b = b2_0;

  always_ff @(posedge clk) begin
    if (s0_cen) a1_0 <= s0_rst ? 1'b0 : s0_ina;
    if (s0_ina) b1_0 <= s0_rst ? 1'b1 : s0_inb;
    a2_0 <= a1_0;
    b2_0 <= b1_0;
  end

  ff_stim_check #(
    .SEED(16'hACE1), .NUM_VECTORS(N0),
    .EXTRA_LAT(0), .ERR_W(8)
  ) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .stim_cen(s0_cen), .stim_rst(s0_rst),
    .stim_ina(s0_ina), .stim_inb(s0_inb),
    .resp_a(r0_a), .resp_b(r0_b),
    .busy(u0_busy), .done(u0_done), .pass(u0_pass),
    .err_count(u0_err), .first_err_idx(u0_first)
  );

  // u1 (EXTRA_LAT=3) and u2 (EXTRA_LAT=2) share one DUT + 3 regs
  logic s1_cen, s1_rst, s1_ina, s1_inb;
  logic s2_cen, s2_rst, s2_ina, s2_inb;
  logic a1_1, b1_1, a2_1, b2_1;
  logic [2:0] da, db;
  logic u1_busy, u1_done, u1_pass;
  logic u2_busy, u2_done, u2_pass;
  logic [7:0]  u1_err, u2_err;
  logic [15:0] u1_first, u2_first;

  always_ff @(posedge clk) begin
    if (s1_cen) a1_1 <= s1_rst ? 1'b0 : s1_ina;
    if (s1_ina) b1_1 <= s1_rst ? 1'b1 : s1_inb;
    a2_1 <= a1_1;
    b2_1 <= b1_1;
    da   <= {da[1:0], a2_1};
    db   <= {db[1:0], b2_1};
  end

  ff_stim_check #(
    .SEED(16'hACE1), .NUM_VECTORS(N0),
    .EXTRA_LAT(3), .ERR_W(8)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .stim_cen(s1_cen), .stim_rst(s1_rst),
    .stim_ina(s1_ina), .stim_inb(s1_inb),
    .resp_a(da[2]), .resp_b(db[2]),
    .busy(u1_busy), .done(u1_done), .pass(u1_pass),
    .err_count(u1_err), .first_err_idx(u1_first)
  );

  ff_stim_check #(
    .SEED(16'hACE1), .NUM_VECTORS(N0),
    .EXTRA_LAT(2), .ERR_W(8)
  ) u2 (
    .clk(clk), .rst(rst), .start(start1),
    .stim_cen(s2_cen), .stim_rst(s2_rst),
    .stim_ina(s2_ina), .stim_inb(s2_inb),
    .resp_a(da[2]), .resp_b(db[2]),
    .busy(u2_busy), .done(u2_done), .pass(u2_pass),
    .err_count(u2_err), .first_err_idx(u2_first)
  );

  // u3: 1024 vectors, resp_a always inverted
  logic s3_cen, s3_rst, s3_ina, s3_inb;
  logic a1_3, b1_3, a2_3, b2_3;
  logic u3_busy, u3_done, u3_pass;
  logic [7:0]  u3_err;
  logic [15:0] u3_first;

  always_ff @(posedge clk) begin
    if (s3_cen) a1_3 <= s3_rst ? 1'b0 : s3_ina;
    if (s3_ina) b1_3 <= s3_rst ? 1'b1 : s3_inb;
    a2_3 <= a1_3;
    b2_3 <= b1_3;
  end

  ff_stim_check #(
    .SEED(16'hACE1), .NUM_VECTORS(1024),
    .EXTRA_LAT(0), .ERR_W(8)
  ) u3 (
    .clk(clk), .rst(rst), .start(start1),
    .stim_cen(s3_cen), .stim_rst(s3_rst),
    .stim_ina(s3_ina), .stim_inb(s3_inb),
    .resp_a(~a2_3), .resp_b(b2_3),
    .busy(u3_busy), .done(u3_done), .pass(u3_pass),
    .err_count(u3_err), .first_err_idx(u3_first)
  );

  function automatic logic [15:0] lnext(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] vexp(input int k,
                                      input logic [15:0] l);
    if (k == 0) return 4'b1110;
    return {l[0], l[1] & l[2], l[3], l[4]};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst0(input string tag);
    chk({tag, "_stim"},  32'(s0), 32'h0);
    chk({tag, "_busy"},  32'(u0_busy), 32'h0);
    chk({tag, "_done"},  32'(u0_done), 32'h0);
    chk({tag, "_pass"},  32'(u0_pass), 32'h0);
    chk({tag, "_err"},   32'(u0_err), 32'h0);
    chk({tag, "_first"}, 32'(u0_first), 32'hFFFF);
  endtask

  // One u0 run; fk = vector whose resp_a sample is inverted.
  task automatic run0(input string tag, input int fk,
                      input int hold, input int abort_at,
                      input logic [7:0] xerr,
                      input logic [15:0] xfirst,
                      input logic xpass);
    logic [15:0] l;
    l = 16'hACE1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = (hold > 0);
    for (int j = 0; j < N0 + 4; j++) begin
      @(posedge clk); #1;
      if (hold > 0 && j == hold) start0 = 1'b0;
      if (j == 0) begin
        chk({tag, "_busy_up"}, 32'(u0_busy), 32'h1);
        chk({tag, "_done_lo"}, 32'(u0_done), 32'h0);
      end
      if (j < N0) begin
        chk($sformatf("%s_stim%0d", tag, j), 32'(s0),
            32'(vexp(j, l)));
        l = lnext(l);
      end else if (j == N0) begin
        chk({tag, "_stim_drain"}, 32'(s0), 32'h0);
      end
      if (fk >= 0 && j == fk + 2) inj = 1'b1;
      if (fk >= 0 && j == fk + 3) inj = 1'b0;
      if (j == abort_at) begin
        rst = 1'b0;
        @(posedge clk); #1;
        chk_rst0({tag, "_abort"});
        rst = 1'b1;
        return;
      end
      if (j == N0 + 2) chk({tag, "_done_early"}, 32'(u0_done), 32'h0);
    end
    chk({tag, "_done"},  32'(u0_done), 32'h1);
    chk({tag, "_busy"},  32'(u0_busy), 32'h0);
    chk({tag, "_err"},   32'(u0_err), 32'(xerr));
    chk({tag, "_first"}, 32'(u0_first), 32'(xfirst));
    chk({tag, "_pass"},  32'(u0_pass), 32'(xpass));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_rst0("reset");
    chk("reset_u3_first", 32'(u3_first), 32'hFFFF);
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    run0("clean", -1, 0, -1, 8'd0, 16'hFFFF, 1'b1);
    run0("fault", 10, 0, -1, 8'd1, 16'd10, 1'b0);
    run0("hold", -1, 40, -1, 8'd0, 16'hFFFF, 1'b1);
    run0("abort", -1, 0, 20, 8'd0, 16'hFFFF, 1'b0);
    run0("rerun", -1, 0, -1, 8'd0, 16'hFFFF, 1'b1);

    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int c = 0; c < 1100 && !u3_done; c++) begin
      @(posedge clk); #1;
    end
    chk("sat_done",  32'(u3_done), 32'h1);
    chk("sat_err",   32'(u3_err), 32'hFF);
    chk("sat_first", 32'(u3_first), 32'h0);
    chk("sat_pass",  32'(u3_pass), 32'h0);
    chk("lat3_done", 32'(u1_done), 32'h1);
    chk("lat3_err",  32'(u1_err), 32'h0);
    chk("lat3_pass", 32'(u1_pass), 32'h1);
    chk("lat2_done", 32'(u2_done), 32'h1);
    chk("lat2_pass", 32'(u2_pass), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
